// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: arbitrates pipeline-register
// enables and bubble injection, tracks the EX bubble flag, perf counters and dmem timeout.
module pipeline_hazard_controller #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             redirect_EX,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             pc_sel_redirect,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             flush_IF_ID,
    output logic             bubble_ID_EX,
    output logic             is_bubble_EX,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [TO_W-1:0]   r_to_cnt;
    logic [TO_W-1:0]   w_to_cnt_next;
    logic              r_bus_err;
    logic              w_bus_err_next;
    logic              w_redirect_taken;
    logic              w_service;
    logic              w_dmem_stall;
    logic              w_count_stall;
    logic              r_is_bubble_ex;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    assign w_dmem_stall = dmem_req_MEM && !dmem_ready;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        w_next_state     = r_state;
        w_to_cnt_next    = r_to_cnt;
        w_bus_err_next   = 1'b0;
        w_redirect_taken = 1'b0;
        w_service        = 1'b0;
        pc_en            = 1'b0;
        pc_sel_redirect  = 1'b0;
        if_id_en         = 1'b0;
        id_ex_en         = 1'b0;
        ex_mem_en        = 1'b0;
        mem_wb_en        = 1'b0;
        flush_IF_ID      = 1'b0;
        bubble_ID_EX     = 1'b0;
        halted           = 1'b0;

        unique case (r_state)
            RUN: begin
                if (halt_req) begin
                    w_next_state = HALT;
                end else if (w_dmem_stall) begin
                    w_next_state  = MEM_WAIT;
                    w_to_cnt_next = TO_W'(1);
                end else begin
                    w_service = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    w_service     = 1'b1;
                    w_next_state  = RUN;
                    w_to_cnt_next = '0;
                end else if (r_to_cnt >= TO_LAST) begin
                    // Abandon the access: let MEM/WB advance past the stuck instruction.
                    mem_wb_en      = 1'b1;
                    w_bus_err_next = 1'b1;
                    w_next_state   = RUN;
                    w_to_cnt_next  = '0;
                end else begin
                    w_to_cnt_next = r_to_cnt + 1'b1;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next_state = RUN;
            end
        endcase

        // Redirect outranks load-use: the dependent instruction in ID is flushed anyway.
        if (w_service) begin
            if (redirect_EX) begin
                pc_en            = 1'b1;
                pc_sel_redirect  = 1'b1;
                if_id_en         = 1'b1;
                id_ex_en         = 1'b1;
                ex_mem_en        = 1'b1;
                mem_wb_en        = 1'b1;
                flush_IF_ID      = 1'b1;
                bubble_ID_EX     = 1'b1;
                w_redirect_taken = 1'b1;
            end else if (load_use) begin
                id_ex_en     = 1'b1;
                bubble_ID_EX = 1'b1;
                ex_mem_en    = 1'b1;
                mem_wb_en    = 1'b1;
            end else if (!imem_ready) begin
                if_id_en    = 1'b1;
                flush_IF_ID = 1'b1;
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
            end
        end

        if (!rst) begin
            pc_en           = 1'b0;
            pc_sel_redirect = 1'b0;
            if_id_en        = 1'b0;
            id_ex_en        = 1'b0;
            ex_mem_en       = 1'b0;
            mem_wb_en       = 1'b0;
            flush_IF_ID     = 1'b1;
            bubble_ID_EX    = 1'b1;
            halted          = 1'b0;
        end
    end

    assign w_count_stall = (r_state != HALT) && !pc_en;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= RUN;
            r_to_cnt       <= '0;
            r_bus_err      <= 1'b0;
            r_is_bubble_ex <= 1'b1;
            r_stall_cnt    <= '0;
            r_flush_cnt    <= '0;
        end else begin
            r_state   <= w_next_state;
            r_to_cnt  <= w_to_cnt_next;
            r_bus_err <= w_bus_err_next;
            if (id_ex_en) begin
                r_is_bubble_ex <= bubble_ID_EX;
            end
            if (w_count_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_redirect_taken && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign is_bubble_EX = r_is_bubble_ex;
    assign bus_err      = r_bus_err;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: each task drives one scenario and
// compares outputs inline against hand-computed values.
module tb_pipeline_hazard_controller;

    localparam int CNT_W = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int TO_W = 3;

    // Control vector: {pc_en, pc_sel, if_id, id_ex, ex_mem, mem_wb, flush, bubble, halted}
    localparam logic [8:0] C_RESET  = 9'b000000110;
    localparam logic [8:0] C_NORMAL = 9'b101111000;
    localparam logic [8:0] C_FREEZE = 9'b000000000;
    localparam logic [8:0] C_LU     = 9'b000111010;
    localparam logic [8:0] C_REDIR  = 9'b111111110;
    localparam logic [8:0] C_IMISS  = 9'b001111100;
    localparam logic [8:0] C_TOUT   = 9'b000001000;
    localparam logic [8:0] C_HALT   = 9'b000000001;

    logic clk, rst;
    logic load_use, redirect_EX, dmem_req_MEM, dmem_ready, imem_ready, halt_req;
    logic pc_en, pc_sel_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic flush_IF_ID, bubble_ID_EX, is_bubble_EX, halted, bus_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int compared = 0;
    int mismatched = 0;

    pipeline_hazard_controller #(
        .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst(rst),
        .load_use(load_use), .redirect_EX(redirect_EX),
        .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
        .imem_ready(imem_ready), .halt_req(halt_req),
        .pc_en(pc_en), .pc_sel_redirect(pc_sel_redirect),
        .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .flush_IF_ID(flush_IF_ID), .bubble_ID_EX(bubble_ID_EX),
        .is_bubble_EX(is_bubble_EX), .halted(halted), .bus_err(bus_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ctl();
        return {pc_en, pc_sel_redirect, if_id_en, id_ex_en, ex_mem_en,
                mem_wb_en, flush_IF_ID, bubble_ID_EX, halted};
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_use = 0; redirect_EX = 0; dmem_req_MEM = 0;
        dmem_ready = 1; imem_ready = 1; halt_req = 0;
    endtask

    // Leaves the bench in the first post-reset cycle, 1 unit after the edge.
    task automatic apply_reset();
        idle_inputs();
        rst = 0;
        cyc();
        cyc();
        rst = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        cyc();
        #4;
        compared++; if (ctl() !== C_RESET) begin mismatched++; $display("FAIL reset_ctl: got %b expected %b", ctl(), C_RESET); end
        compared++; if ({is_bubble_EX, bus_err} !== 2'b10) begin mismatched++; $display("FAIL reset_regs: got %b expected 10", {is_bubble_EX, bus_err}); end
        compared++; if ({stall_cnt, flush_cnt} !== '0) begin mismatched++; $display("FAIL reset_cnts: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        cyc();
        rst = 1;
        #4;
        compared++; if (ctl() !== C_NORMAL) begin mismatched++; $display("FAIL release_ctl: got %b expected %b", ctl(), C_NORMAL); end
        compared++; if (is_bubble_EX !== 1'b1) begin mismatched++; $display("FAIL release_bubble: got %b expected 1", is_bubble_EX); end
        cyc();
        compared++; if (is_bubble_EX !== 1'b0) begin mismatched++; $display("FAIL release_bubble2: got %b expected 0", is_bubble_EX); end
        compared++; if (stall_cnt !== 4'd0) begin mismatched++; $display("FAIL release_stall: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_load_use();
        apply_reset();
        load_use = 1;
        #4;
        compared++; if (ctl() !== C_LU) begin mismatched++; $display("FAIL lu_ctl: got %b expected %b", ctl(), C_LU); end
        cyc();
        load_use = 0;
        compared++; if (is_bubble_EX !== 1'b1) begin mismatched++; $display("FAIL lu_bubble: got %b expected 1", is_bubble_EX); end
        compared++; if (stall_cnt !== 4'd1) begin mismatched++; $display("FAIL lu_stall: got %0d expected 1", stall_cnt); end
        #4;
        compared++; if (ctl() !== C_NORMAL) begin mismatched++; $display("FAIL lu_after_ctl: got %b expected %b", ctl(), C_NORMAL); end
        cyc();
        compared++; if (is_bubble_EX !== 1'b0) begin mismatched++; $display("FAIL lu_bubble_clr: got %b expected 0", is_bubble_EX); end
    endtask

    task automatic test_redirect_over_load_use();
        apply_reset();
        redirect_EX = 1; load_use = 1;
        #4;
        compared++; if (ctl() !== C_REDIR) begin mismatched++; $display("FAIL redir_ctl: got %b expected %b", ctl(), C_REDIR); end
        cyc();
        redirect_EX = 0; load_use = 0;
        compared++; if ({flush_cnt, stall_cnt} !== {4'd1, 4'd0}) begin mismatched++; $display("FAIL redir_cnts: got flush %0d stall %0d expected 1/0", flush_cnt, stall_cnt); end
        compared++; if (is_bubble_EX !== 1'b1) begin mismatched++; $display("FAIL redir_bubble: got %b expected 1", is_bubble_EX); end
    endtask

    task automatic test_imem_miss();
        apply_reset();
        imem_ready = 0;
        #4;
        compared++; if (ctl() !== C_IMISS) begin mismatched++; $display("FAIL imiss_ctl: got %b expected %b", ctl(), C_IMISS); end
        cyc();
        load_use = 1;
        #4;
        compared++; if (ctl() !== C_LU) begin mismatched++; $display("FAIL imiss_lu_ctl: got %b expected %b", ctl(), C_LU); end
        cyc();
        idle_inputs();
        compared++; if (stall_cnt !== 4'd2) begin mismatched++; $display("FAIL imiss_stall: got %0d expected 2", stall_cnt); end
    endtask

    // Redirect held pending while memory stalls; it must be serviced on the ready cycle.
    task automatic test_mem_wait();
        apply_reset();
        dmem_req_MEM = 1; dmem_ready = 0; redirect_EX = 1;
        for (int i = 0; i < 3; i++) begin
            #4;
            compared++; if (ctl() !== C_FREEZE) begin mismatched++; $display("FAIL mw_freeze[%0d]: got %b expected %b", i, ctl(), C_FREEZE); end
            cyc();
        end
        compared++; if (stall_cnt !== 4'd3) begin mismatched++; $display("FAIL mw_stall: got %0d expected 3", stall_cnt); end
        dmem_ready = 1;
        #4;
        compared++; if (ctl() !== C_REDIR) begin mismatched++; $display("FAIL mw_release_ctl: got %b expected %b", ctl(), C_REDIR); end
        cyc();
        idle_inputs();
        #4;
        compared++; if (ctl() !== C_NORMAL) begin mismatched++; $display("FAIL mw_run_ctl: got %b expected %b", ctl(), C_NORMAL); end
        compared++; if ({flush_cnt, stall_cnt, bus_err} !== {4'd1, 4'd3, 1'b0}) begin mismatched++; $display("FAIL mw_cnts: got flush %0d stall %0d err %b expected 1/3/0", flush_cnt, stall_cnt, bus_err); end
        cyc();
    endtask

    task automatic test_timeout();
        int pulses;
        logic [8:0] exp_ctl [4];
        exp_ctl[0] = C_FREEZE; exp_ctl[1] = C_FREEZE; exp_ctl[2] = C_FREEZE; exp_ctl[3] = C_TOUT;
        pulses = 0;
        apply_reset();
        dmem_req_MEM = 1; dmem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #4;
            compared++; if (ctl() !== exp_ctl[i]) begin mismatched++; $display("FAIL to_ctl[%0d]: got %b expected %b", i, ctl(), exp_ctl[i]); end
            if (bus_err) pulses++;
            cyc();
        end
        dmem_req_MEM = 0; dmem_ready = 1;
        compared++; if (bus_err !== 1'b1) begin mismatched++; $display("FAIL to_err_pulse: got %b expected 1", bus_err); end
        #4;
        compared++; if (ctl() !== C_NORMAL) begin mismatched++; $display("FAIL to_run_ctl: got %b expected %b", ctl(), C_NORMAL); end
        for (int i = 0; i < 3; i++) begin
            if (bus_err) pulses++;
            cyc();
        end
        compared++; if (pulses !== 1) begin mismatched++; $display("FAIL to_pulses: got %0d expected 1", pulses); end
        compared++; if (stall_cnt !== 4'd4) begin mismatched++; $display("FAIL to_stall: got %0d expected 4", stall_cnt); end
    endtask

    task automatic test_halt_then_async_reset();
        apply_reset();
        halt_req = 1; dmem_req_MEM = 1; dmem_ready = 0;
        #4;
        compared++; if (ctl() !== C_FREEZE) begin mismatched++; $display("FAIL halt_req_ctl: got %b expected %b", ctl(), C_FREEZE); end
        cyc();
        idle_inputs();
        redirect_EX = 1; load_use = 1;
        for (int i = 0; i < 3; i++) begin
            #4;
            compared++; if (ctl() !== C_HALT) begin mismatched++; $display("FAIL halt_ctl[%0d]: got %b expected %b", i, ctl(), C_HALT); end
            cyc();
        end
        compared++; if ({stall_cnt, flush_cnt} !== {4'd1, 4'd0}) begin mismatched++; $display("FAIL halt_cnts: got %0d/%0d expected 1/0", stall_cnt, flush_cnt); end
        #2;
        rst = 0;
        #1;
        compared++; if (ctl() !== C_RESET) begin mismatched++; $display("FAIL async_rst_ctl: got %b expected %b", ctl(), C_RESET); end
        compared++; if ({stall_cnt, is_bubble_EX} !== {4'd0, 1'b1}) begin mismatched++; $display("FAIL async_rst_regs: got stall %0d bubble %b expected 0/1", stall_cnt, is_bubble_EX); end
        idle_inputs();
        cyc();
        rst = 1;
        #4;
        compared++; if (ctl() !== C_NORMAL) begin mismatched++; $display("FAIL post_halt_ctl: got %b expected %b", ctl(), C_NORMAL); end
        cyc();
    endtask

    task automatic test_back_to_back_saturate();
        apply_reset();
        load_use = 1;
        for (int i = 0; i < 20; i++) cyc();
        compared++; if (stall_cnt !== 4'hF) begin mismatched++; $display("FAIL sat_stall: got %0d expected 15", stall_cnt); end
        load_use = 0; redirect_EX = 1;
        for (int i = 0; i < 17; i++) cyc();
        redirect_EX = 0;
        compared++; if ({flush_cnt, stall_cnt} !== {4'hF, 4'hF}) begin mismatched++; $display("FAIL sat_flush: got flush %0d stall %0d expected 15/15", flush_cnt, stall_cnt); end
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        test_reset();
        test_load_use();
        test_redirect_over_load_use();
        test_imem_miss();
        test_mem_wait();
        test_timeout();
        test_halt_then_async_reset();
        test_back_to_back_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
